// File: rtl/segre_id_stage.sv
// segre_id_stage: RV32I decode stage with integer register file and ID/EX output register

package segre_pkg;
    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 32;
    localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [2:0] {IF_STATE, ID_STATE, EX_STATE, MEM_STATE, WB_STATE} fsm_state_e;
    typedef enum logic [1:0] {BYTE, HALF, WORD} memop_data_type_e;
endpackage

module segre_id_stage
    import segre_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  fsm_state_e            fsm_state_i,
    input  logic [WORD_SIZE-1:0]  instr_i,
    input  logic [ADDR_SIZE-1:0]  pc_i,
    input  logic                  rf_we_i,
    input  logic [REG_ADDR_W-1:0] rf_waddr_i,
    input  logic [WORD_SIZE-1:0]  rf_wdata_i,
    output logic [WORD_SIZE-1:0]  rs1_data_o,
    output logic [WORD_SIZE-1:0]  rs2_data_o,
    output logic [WORD_SIZE-1:0]  imm_o,
    output logic [ADDR_SIZE-1:0]  pc_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic [3:0]            alu_op_o,
    output logic                  alu_src_a_o,
    output logic                  alu_src_b_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output memop_data_type_e      mem_type_o,
    output logic                  mem_unsigned_o,
    output logic                  rf_we_o,
    output logic                  br_o,
    output logic [2:0]            br_cond_o,
    output logic                  jump_o,
    output logic                  jalr_o,
    output logic                  illegal_o
);
    localparam logic [6:0] OPC_LOAD = 7'h03, OPC_FENCE = 7'h0F, OPC_OP_IMM = 7'h13, OPC_AUIPC = 7'h17,
                           OPC_STORE = 7'h23, OPC_OP = 7'h33, OPC_LUI = 7'h37, OPC_BRANCH = 7'h63,
                           OPC_JALR = 7'h67, OPC_JAL = 7'h6F, OPC_SYSTEM = 7'h73;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
                           ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9,
                           ALU_PASS_B = 4'd10;

    typedef struct packed {
        logic [WORD_SIZE-1:0]  rs1_data;
        logic [WORD_SIZE-1:0]  rs2_data;
        logic [WORD_SIZE-1:0]  imm;
        logic [ADDR_SIZE-1:0]  pc;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [3:0]            alu_op;
        logic                  alu_src_a;
        logic                  alu_src_b;
        logic                  mem_rd;
        logic                  mem_wr;
        memop_data_type_e      mem_type;
        logic                  mem_unsigned;
        logic                  rf_we;
        logic                  br;
        logic [2:0]            br_cond;
        logic                  jump;
        logic                  jalr;
        logic                  illegal;
    } id_out_t;

    logic [WORD_SIZE-1:0]  rf_q [NUM_REGS];
    logic [WORD_SIZE-1:0]  rf_d [NUM_REGS];
    id_out_t               out_q, out_d, dec;
    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic [3:0]            alu_f;
    logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx;
    logic [WORD_SIZE-1:0]  rs1_rd, rs2_rd, imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode  = instr_i[6:0];
    assign f3      = instr_i[14:12];
    assign rs1_idx = instr_i[19:15];
    assign rs2_idx = instr_i[24:20];
    assign imm_i   = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b   = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u   = {instr_i[31:12], 12'b0};
    assign imm_j   = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // A pending writeback to the same index is forwarded so the captured operand is never stale
    assign rs1_rd = (rs1_idx == '0) ? '0 : (rf_we_i && rf_waddr_i == rs1_idx) ? rf_wdata_i : rf_q[rs1_idx];
    assign rs2_rd = (rs2_idx == '0) ? '0 : (rf_we_i && rf_waddr_i == rs2_idx) ? rf_wdata_i : rf_q[rs2_idx];

    // SUB only exists for register-register ops; funct7[5] selects arithmetic right shift for both forms
    assign alu_f = f3 == 3'd0 ? ((opcode == OPC_OP && instr_i[30]) ? ALU_SUB : ALU_ADD) :
                   f3 == 3'd1 ? ALU_SLL : f3 == 3'd2 ? ALU_SLT : f3 == 3'd3 ? ALU_SLTU :
                   f3 == 3'd4 ? ALU_XOR : f3 == 3'd5 ? (instr_i[30] ? ALU_SRA : ALU_SRL) :
                   f3 == 3'd6 ? ALU_OR : ALU_AND;

    // Register file next state: writeback in WB_STATE only, x0 never written
    always_comb begin
        rf_d = rf_q;
        if (rf_we_i && fsm_state_i == WB_STATE && rf_waddr_i != '0) rf_d[rf_waddr_i] = rf_wdata_i;
    end

    // Instruction decode; illegal encodings keep their datapath fields but lose all side effects
    always_comb begin
        dec          = '0;
        dec.mem_type = WORD;
        dec.rs1_data = rs1_rd;
        dec.rs2_data = rs2_rd;
        dec.pc       = pc_i;
        dec.rd_addr  = instr_i[11:7];
        case (opcode)
            OPC_OP: begin
                dec.alu_op = alu_f;
                dec.rf_we  = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_op    = alu_f;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_i;
                dec.rf_we     = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_src_b    = 1'b1;
                dec.imm          = imm_i;
                dec.mem_rd       = 1'b1;
                dec.rf_we        = 1'b1;
                dec.mem_type     = memop_data_type_e'(f3[1:0]);
                dec.mem_unsigned = f3[2];
                dec.illegal      = f3 == 3'd3;
            end
            OPC_STORE: begin
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_s;
                dec.mem_wr    = 1'b1;
                dec.mem_type  = memop_data_type_e'(f3[1:0]);
                dec.illegal   = f3 > 3'd2;
            end
            OPC_LUI: begin
                dec.alu_op    = ALU_PASS_B;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_u;
                dec.rf_we     = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_u;
                dec.rf_we     = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_j;
                dec.jump      = 1'b1;
                dec.rf_we     = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm       = imm_i;
                dec.jump      = 1'b1;
                dec.jalr      = 1'b1;
                dec.rf_we     = 1'b1;
            end
            OPC_BRANCH: begin
                dec.br      = 1'b1;
                dec.alu_op  = ALU_SUB;
                dec.imm     = imm_b;
                dec.br_cond = f3;
                dec.illegal = f3 == 3'd2 || f3 == 3'd3;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.rf_we  = 1'b0;
            dec.mem_rd = 1'b0;
            dec.mem_wr = 1'b0;
            dec.br     = 1'b0;
            dec.jump   = 1'b0;
        end
        if (dec.rd_addr == '0) dec.rf_we = 1'b0;
    end

    // Output register captures the decode only in ID_STATE and holds otherwise
    always_comb begin
        out_d = (fsm_state_i == ID_STATE) ? dec : out_q;
    end

    // State update; reset drops both the pending decode and the pending writeback
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q          <= '0;
            out_q.mem_type <= WORD;
            rf_q           <= '{default: '0};
        end else begin
            out_q <= out_d;
            rf_q  <= rf_d;
        end
    end

    assign rs1_data_o     = out_q.rs1_data;
    assign rs2_data_o     = out_q.rs2_data;
    assign imm_o          = out_q.imm;
    assign pc_o           = out_q.pc;
    assign rd_addr_o      = out_q.rd_addr;
    assign alu_op_o       = out_q.alu_op;
    assign alu_src_a_o    = out_q.alu_src_a;
    assign alu_src_b_o    = out_q.alu_src_b;
    assign mem_rd_o       = out_q.mem_rd;
    assign mem_wr_o       = out_q.mem_wr;
    assign mem_type_o     = out_q.mem_type;
    assign mem_unsigned_o = out_q.mem_unsigned;
    assign rf_we_o        = out_q.rf_we;
    assign br_o           = out_q.br;
    assign br_cond_o      = out_q.br_cond;
    assign jump_o         = out_q.jump;
    assign jalr_o         = out_q.jalr;
    assign illegal_o      = out_q.illegal;
endmodule

// File: tb/tb_segre_id_stage.sv
// tb_segre_id_stage: directed and randomized checks of the decode stage against a behavioural model
module tb_segre_id_stage;
    import segre_pkg::*;

    logic             clk = 1'b0;
    logic             rst_i;
    fsm_state_e       fsm_state_i;
    logic [31:0]      instr_i, pc_i, rf_wdata_i;
    logic             rf_we_i;
    logic [4:0]       rf_waddr_i;
    logic [31:0]      rs1_data_o, rs2_data_o, imm_o, pc_o;
    logic [4:0]       rd_addr_o;
    logic [3:0]       alu_op_o;
    logic             alu_src_a_o, alu_src_b_o, mem_rd_o, mem_wr_o, mem_unsigned_o, rf_we_o, br_o;
    memop_data_type_e mem_type_o;
    logic [2:0]       br_cond_o;
    logic             jump_o, jalr_o, illegal_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] regs [32];

    typedef struct packed {
        logic [31:0] rs1, rs2, imm, pc;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        sa, sb, mrd, mwr;
        logic [1:0]  mt;
        logic        mu, we, br;
        logic [2:0]  bc;
        logic        j, jr, ill;
    } exp_t;

    always #5 clk = ~clk;

    segre_id_stage dut (
        .clk_i(clk), .rst_i(rst_i), .fsm_state_i(fsm_state_i), .instr_i(instr_i), .pc_i(pc_i),
        .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o), .pc_o(pc_o),
        .rd_addr_o(rd_addr_o), .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_type_o(mem_type_o), .mem_unsigned_o(mem_unsigned_o),
        .rf_we_o(rf_we_o), .br_o(br_o), .br_cond_o(br_cond_o), .jump_o(jump_o), .jalr_o(jalr_o),
        .illegal_o(illegal_o)
    );

    function automatic exp_t observed();
        return '{rs1_data_o, rs2_data_o, imm_o, pc_o, rd_addr_o, alu_op_o, alu_src_a_o, alu_src_b_o,
                 mem_rd_o, mem_wr_o, mem_type_o, mem_unsigned_o, rf_we_o, br_o, br_cond_o,
                 jump_o, jalr_o, illegal_o};
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] idx, input logic we, input logic [4:0] wa,
                                         input logic [31:0] wd);
        if (idx == 0) return 0;
        if (we && wa == idx) return wd;
        return regs[idx];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic we,
                                   input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        int si, arith, imm_i, imm_s, imm_b, imm_u, imm_j;
        int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [6:0] op;
        logic [2:0] f3;
        logic bad, known;
        op = ins[6:0];
        f3 = ins[14:12];
        si = ins;
        imm_i = si >>> 20;
        imm_s = ((si >>> 25) << 5) | int'(ins[11:7]);
        imm_b = ((si >>> 31) << 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
        imm_u = si & 32'hFFFF_F000;
        imm_j = ((si >>> 31) << 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
        arith = alu_tab[f3];
        if (ins[30] && f3 == 5) arith = 7;
        if (ins[30] && f3 == 0 && op == 7'h33) arith = 1;
        known = op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        bad = !known || (op == 7'h03 && f3 == 3) || (op == 7'h23 && f3 > 2) || (op == 7'h63 && (f3 == 2 || f3 == 3));
        e = '0;
        e.rs1 = opnd(ins[19:15], we, wa, wd);
        e.rs2 = opnd(ins[24:20], we, wa, wd);
        e.pc  = pc;
        e.rd  = ins[11:7];
        e.ill = bad;
        e.alu = (op == 7'h33 || op == 7'h13) ? 4'(arith) : op == 7'h37 ? 4'd10 : op == 7'h63 ? 4'd1 : 4'd0;
        e.sa  = op inside {7'h17, 7'h6F, 7'h67};
        e.sb  = op inside {7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67};
        e.imm = op inside {7'h13, 7'h03, 7'h67} ? imm_i : op == 7'h23 ? imm_s : op == 7'h63 ? imm_b :
                op inside {7'h37, 7'h17} ? imm_u : op == 7'h6F ? imm_j : 0;
        e.mt  = op inside {7'h03, 7'h23} ? f3[1:0] : 2'd2;
        e.mu  = op == 7'h03 && f3[2];
        e.bc  = op == 7'h63 ? f3 : 3'd0;
        e.jr  = op == 7'h67;
        e.we  = !bad && e.rd != 0 && op inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
        e.mrd = !bad && op == 7'h03;
        e.mwr = !bad && op == 7'h23;
        e.br  = !bad && op == 7'h63;
        e.j   = !bad && op inside {7'h6F, 7'h67};
        return e;
    endfunction

    task automatic step(input fsm_state_e s, input logic [31:0] ins, input logic [31:0] pc, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input logic rst);
        @(negedge clk);
        rst_i = rst; fsm_state_i = s; instr_i = ins; pc_i = pc;
        rf_we_i = we; rf_waddr_i = wa; rf_wdata_i = wd;
        @(posedge clk);
        #1;
        if (rst) foreach (regs[k]) regs[k] = 0;
        else if (s == WB_STATE && we && wa != 0) regs[wa] = wd;
    endtask

    task automatic test_reset();
        exp_t r;
        r = '0;
        r.mt = 2'd2;
        step(ID_STATE, 32'h123450B7, 32'h40, 1'b1, 5'd3, 32'h77, 1'b1);
        checks++;
        if (observed() !== r) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", observed(), r); end
    endtask

    task automatic test_addi();
        step(ID_STATE, 32'hFFF00293, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if (imm_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got=%h exp=ffffffff", imm_o); end
        checks++;
        if ({rd_addr_o, alu_op_o, alu_src_b_o, rf_we_o, rs1_data_o, pc_o} !== {5'd5, 4'd0, 1'b1, 1'b1, 32'h0, 32'h100})
            begin errors++; $display("FAIL addi_ctrl got rd=%0d alu=%0d sb=%b we=%b rs1=%h pc=%h", rd_addr_o, alu_op_o, alu_src_b_o, rf_we_o, rs1_data_o, pc_o); end
    endtask

    task automatic test_rf_read();
        step(WB_STATE, NOP_INSTR, 32'h0, 1'b1, 5'd3, 32'h1234, 1'b0);
        step(ID_STATE, 32'h000183B3, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if ({rs1_data_o, rs2_data_o, alu_src_b_o, rd_addr_o} !== {32'h1234, 32'h0, 1'b0, 5'd7})
            begin errors++; $display("FAIL rf_read got rs1=%h rs2=%h sb=%b rd=%0d exp 1234/0/0/7", rs1_data_o, rs2_data_o, alu_src_b_o, rd_addr_o); end
    endtask

    task automatic test_x0_bypass();
        step(WB_STATE, NOP_INSTR, 32'h0, 1'b1, 5'd0, 32'hDEAD, 1'b0);
        step(ID_STATE, 32'h000003B3, 32'h108, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL x0_read got=%h exp=0", rs1_data_o); end
        step(ID_STATE, 32'h000183B3, 32'h10C, 1'b1, 5'd3, 32'h55, 1'b0);
        checks++;
        if (rs1_data_o !== 32'h55) begin errors++; $display("FAIL bypass got=%h exp=55", rs1_data_o); end
        step(ID_STATE, 32'h000183B3, 32'h110, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if (rs1_data_o !== 32'h1234) begin errors++; $display("FAIL bypass_no_commit got=%h exp=1234", rs1_data_o); end
    endtask

    task automatic test_store_lui();
        step(ID_STATE, 32'h0020A423, 32'h114, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if ({imm_o, mem_wr_o, mem_rd_o, 2'(mem_type_o), rf_we_o} !== {32'd8, 1'b1, 1'b0, 2'd2, 1'b0})
            begin errors++; $display("FAIL store got imm=%h mwr=%b mrd=%b mt=%0d we=%b", imm_o, mem_wr_o, mem_rd_o, mem_type_o, rf_we_o); end
        step(ID_STATE, 32'h123450B7, 32'h118, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if ({imm_o, alu_op_o, rf_we_o, rd_addr_o} !== {32'h12345000, 4'd10, 1'b1, 5'd1})
            begin errors++; $display("FAIL lui got imm=%h alu=%0d we=%b rd=%0d", imm_o, alu_op_o, rf_we_o, rd_addr_o); end
    endtask

    task automatic test_illegal_hold();
        fsm_state_e hold_st[3] = '{EX_STATE, MEM_STATE, WB_STATE};
        logic [31:0] hold_ins[3] = '{32'h123450B7, 32'h0020A423, 32'h000183B3};
        step(ID_STATE, 32'hFFFFFFFF, 32'h11C, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if ({illegal_o, rf_we_o, mem_rd_o, mem_wr_o, br_o, jump_o} !== 6'b100000)
            begin errors++; $display("FAIL illegal got ill=%b we=%b mrd=%b mwr=%b br=%b j=%b", illegal_o, rf_we_o, mem_rd_o, mem_wr_o, br_o, jump_o); end
        for (int i = 0; i < 3; i++) begin
            step(hold_st[i], hold_ins[i], 32'h200, 1'b0, 5'd0, 32'h0, 1'b0);
            checks++;
            if ({illegal_o, imm_o, rd_addr_o, alu_op_o, pc_o} !== {1'b1, 32'h0, 5'd31, 4'd0, 32'h11C})
                begin errors++; $display("FAIL hold[%0d] got ill=%b imm=%h rd=%0d alu=%0d pc=%h", i, illegal_o, imm_o, rd_addr_o, alu_op_o, pc_o); end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        fsm_state_e others[3] = '{IF_STATE, EX_STATE, MEM_STATE};
        exp_t held, e, got;
        fsm_state_e s;
        logic [31:0] ins, pc, wd;
        logic [4:0] wa;
        logic we;
        int r;
        held = '0;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(9);
            s = (i == 0 || r < 4) ? ID_STATE : r < 7 ? WB_STATE : others[$urandom_range(2)];
            ins = $urandom;
            if ($urandom_range(9) < 8) ins[6:0] = ops[$urandom_range(10)];
            we = 1'($urandom_range(1));
            wa = 5'($urandom);
            wd = $urandom;
            pc = $urandom;
            if ($urandom_range(3) == 0) ins[19:15] = wa;
            if ($urandom_range(3) == 0) ins[24:20] = wa;
            e = model(ins, pc, we, wa, wd);
            if (s == ID_STATE) held = e;
            step(s, ins, pc, we, wa, wd, 1'b0);
            got = observed();
            checks++;
            if (got !== held) begin errors++; $display("FAIL random[%0d] ins=%h got=%h exp=%h", i, ins, got, held); end
        end
    endtask

    task automatic test_reset_clear();
        exp_t r;
        r = '0;
        r.mt = 2'd2;
        step(WB_STATE, NOP_INSTR, 32'h0, 1'b1, 5'd4, 32'hAAAA, 1'b0);
        step(ID_STATE, 32'h123450B7, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0);
        step(WB_STATE, NOP_INSTR, 32'h0, 1'b1, 5'd5, 32'hBBBB, 1'b1);
        checks++;
        if (observed() !== r) begin errors++; $display("FAIL reset_mid got=%h exp=%h", observed(), r); end
        for (int i = 1; i < 32; i++) begin
            step(ID_STATE, (32'(i) << 20) | (32'(i) << 15) | 32'h33, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
            checks++;
            if ({rs1_data_o, rs2_data_o} !== 64'h0)
                begin errors++; $display("FAIL reg_cleared x%0d got rs1=%h rs2=%h exp=0", i, rs1_data_o, rs2_data_o); end
        end
    endtask

    initial begin
        rst_i = 1'b1; fsm_state_i = IF_STATE; instr_i = NOP_INSTR; pc_i = '0;
        rf_we_i = 1'b0; rf_waddr_i = '0; rf_wdata_i = '0;
        foreach (regs[k]) regs[k] = 0;
        test_reset();
        test_addi();
        test_rf_read();
        test_x0_bypass();
        test_store_lui();
        test_illegal_hold();
        test_random();
        test_reset_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
